// File: rtl/wfid_alloc_ctrl.sv
// Wavefront-ID allocation controller: owns the vacant mask, runs the alloc handshake, round-robins releases.
// Alloc ack one cycle after the gen_wr cycle (one grant per two cycles); losing release sources hold done_valid.
module wfid_alloc_ctrl #(
  parameter int NUM_WF  = 40,
  parameter int ID_W    = 6,
  parameter int TAG_W   = 15,
  parameter int NUM_SRC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc_req,
  input  logic [TAG_W-1:0]        alloc_tag,
  output logic                    alloc_ack,
  output logic [ID_W-1:0]         alloc_wfid,
  input  logic                    drain,
  input  logic [NUM_SRC-1:0]      done_valid,
  input  logic [NUM_SRC*ID_W-1:0] done_wfid,
  output logic [NUM_SRC-1:0]      done_ready,
  output logic                    gen_wr,
  output logic [TAG_W-1:0]        gen_tag,
  output logic                    gen_halt,
  output logic [ID_W-1:0]         gen_wfid_done,
  output logic [NUM_WF-1:0]       gen_vacant,
  input  logic [NUM_WF-1:0]       gen_vacant_next,
  input  logic [ID_W-1:0]         gen_wfid,
  input  logic [TAG_W-1:0]        gen_tag_done,
  output logic                    retire_valid,
  output logic [ID_W-1:0]         retire_wfid,
  output logic [TAG_W-1:0]        retire_tag,
  output logic [ID_W:0]           free_count,
  output logic                    all_idle,
  output logic                    err_double_free
);

  localparam int RR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [ID_W:0] CNT_ONE  = (ID_W+1)'(1);
  localparam logic [ID_W:0] CNT_FULL = (ID_W+1)'(NUM_WF);

  typedef enum logic {IDLE, ACK} state_t;

  state_t            state, state_nxt;
  logic [NUM_WF-1:0] vacant;
  logic [ID_W-1:0]   wfid_q;
  logic [ID_W:0]     free_cnt;
  logic [RR_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   src_id [NUM_SRC];
  logic              win_any;
  logic [RR_W-1:0]   win_idx;
  logic [ID_W-1:0]   win_id;
  logic              win_dbl;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) src_id[i] = done_wfid[i*ID_W +: ID_W];
  end

  // First requester at or after rr_ptr wins, wrapping around the source list.
  always_comb begin
    int s;
    logic [RR_W-1:0] cand;
    s       = 0;
    cand    = '0;
    win_any = 1'b0;
    win_idx = '0;
    for (int off = 0; off < NUM_SRC; off++) begin
      s = int'(rr_ptr) + off;
      if (s >= NUM_SRC) s = s - NUM_SRC;
      cand = RR_W'(s);
      if (!win_any && done_valid[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
  end

  // An id outside the slot range is rejected exactly like a release of a vacant slot.
  always_comb begin
    win_id  = src_id[win_idx];
    win_dbl = (int'(win_id) >= NUM_WF) ? 1'b1 : vacant[win_id];
    done_ready = '0;
    if (win_any) done_ready[win_idx] = 1'b1;
    gen_halt      = win_any && !win_dbl;
    gen_wfid_done = win_any ? win_id : '0;
  end

  always_comb begin
    state_nxt  = state;
    gen_wr     = 1'b0;
    alloc_ack  = 1'b0;
    alloc_wfid = '0;
    case (state)
      IDLE: begin
        if (alloc_req && !drain && (|vacant)) begin
          gen_wr    = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        alloc_ack  = 1'b1;
        alloc_wfid = wfid_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      wfid_q          <= '0;
      vacant          <= '1;
      free_cnt        <= CNT_FULL;
      rr_ptr          <= '0;
      err_double_free <= 1'b0;
      retire_valid    <= 1'b0;
      retire_wfid     <= '0;
      retire_tag      <= '0;
    end else begin
      state <= state_nxt;
      if (gen_wr) wfid_q <= gen_wfid;
      if (gen_wr || gen_halt) vacant <= gen_vacant_next;
      case ({gen_wr, gen_halt})
        2'b10:   free_cnt <= free_cnt - CNT_ONE;
        2'b01:   free_cnt <= free_cnt + CNT_ONE;
        default: free_cnt <= free_cnt;
      endcase
      if (win_any) begin
        if (int'(win_idx) == NUM_SRC - 1) rr_ptr <= '0;
        else rr_ptr <= win_idx + RR_W'(1);
      end
      if (win_any && win_dbl) err_double_free <= 1'b1;
      retire_valid <= gen_halt;
      if (gen_halt) begin
        retire_wfid <= gen_wfid_done;
        retire_tag  <= gen_tag_done;
      end
    end
  end

  assign gen_tag    = alloc_tag;
  assign gen_vacant = vacant;
  assign free_count = free_cnt;
  assign all_idle   = (free_cnt == CNT_FULL);

endmodule

// File: tb/tb_wfid_alloc_ctrl.sv
// Bench for wfid_alloc_ctrl: emulates the wfid generator and checks against a slot-set reference model.
module tb_wfid_alloc_ctrl;

  localparam int NUM_WF  = 40;
  localparam int ID_W    = 6;
  localparam int TAG_W   = 15;
  localparam int NUM_SRC = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    alloc_req;
  logic [TAG_W-1:0]        alloc_tag;
  logic                    alloc_ack;
  logic [ID_W-1:0]         alloc_wfid;
  logic                    drain;
  logic [NUM_SRC-1:0]      done_valid;
  logic [NUM_SRC*ID_W-1:0] done_wfid;
  logic [NUM_SRC-1:0]      done_ready;
  logic                    gen_wr;
  logic [TAG_W-1:0]        gen_tag;
  logic                    gen_halt;
  logic [ID_W-1:0]         gen_wfid_done;
  logic [NUM_WF-1:0]       gen_vacant;
  logic [NUM_WF-1:0]       gen_vacant_next;
  logic [ID_W-1:0]         gen_wfid;
  logic [TAG_W-1:0]        gen_tag_done;
  logic                    retire_valid;
  logic [ID_W-1:0]         retire_wfid;
  logic [TAG_W-1:0]        retire_tag;
  logic [ID_W:0]           free_count;
  logic                    all_idle;
  logic                    err_double_free;

  int checks = 0;
  int errors = 0;

  // Reference model: which slots are held, the tag each holds, and the round-robin pointer.
  bit             mdl_busy [NUM_WF];
  logic [TAG_W-1:0] mdl_tag [NUM_WF];
  int             mdl_rr;

  wfid_alloc_ctrl #(.NUM_WF(NUM_WF), .ID_W(ID_W), .TAG_W(TAG_W), .NUM_SRC(NUM_SRC)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_tag(alloc_tag), .alloc_ack(alloc_ack), .alloc_wfid(alloc_wfid),
    .drain(drain), .done_valid(done_valid), .done_wfid(done_wfid), .done_ready(done_ready),
    .gen_wr(gen_wr), .gen_tag(gen_tag), .gen_halt(gen_halt), .gen_wfid_done(gen_wfid_done),
    .gen_vacant(gen_vacant), .gen_vacant_next(gen_vacant_next), .gen_wfid(gen_wfid),
    .gen_tag_done(gen_tag_done), .retire_valid(retire_valid), .retire_wfid(retire_wfid),
    .retire_tag(retire_tag), .free_count(free_count), .all_idle(all_idle),
    .err_double_free(err_double_free)
  );

  always #5 clk = ~clk;

  // Generator emulation: lowest vacant id, next-mask computation and tag storage.
  logic [TAG_W-1:0] gen_tag_mem [NUM_WF];
  always_comb begin
    gen_wfid = '0;
    for (int i = NUM_WF - 1; i >= 0; i--) if (gen_vacant[i]) gen_wfid = ID_W'(i);
    gen_vacant_next = gen_vacant;
    if (gen_wr) gen_vacant_next[gen_wfid] = 1'b0;
    if (gen_halt && int'(gen_wfid_done) < NUM_WF) gen_vacant_next[gen_wfid_done] = 1'b1;
    gen_tag_done = (int'(gen_wfid_done) < NUM_WF) ? gen_tag_mem[gen_wfid_done] : '0;
  end
  always @(posedge clk) if (gen_wr) gen_tag_mem[gen_wfid] <= gen_tag;

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (int'(free_count) != $countones(gen_vacant)) begin
        errors++;
        $display("FAIL invariant free_count=%0d popcount(vacant)=%0d", free_count, $countones(gen_vacant));
      end
    end
  end

  function automatic int mdl_free();
    int n = 0;
    for (int i = 0; i < NUM_WF; i++) if (!mdl_busy[i]) n++;
    return n;
  endfunction

  function automatic int mdl_lowest();
    for (int i = 0; i < NUM_WF; i++) if (!mdl_busy[i]) return i;
    return -1;
  endfunction

  function automatic void mdl_reset();
    for (int i = 0; i < NUM_WF; i++) mdl_busy[i] = 1'b0;
    mdl_rr = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds alloc_req until an ack arrives or the budget runs out; got = -1 on timeout.
  task automatic do_alloc(input logic [TAG_W-1:0] tag, input int budget, output int got);
    got       = -1;
    alloc_req = 1'b1;
    alloc_tag = tag;
    for (int c = 0; c < budget && got < 0; c++) begin
      @(negedge clk);
      if (alloc_ack) got = int'(alloc_wfid);
      tick();
    end
    alloc_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; alloc_req = 1'b0; alloc_tag = '0; drain = 1'b0; done_valid = '0; done_wfid = '0;
    mdl_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (free_count !== 7'd40 || all_idle !== 1'b1) begin
      errors++; $display("FAIL reset_count free_count=%0d all_idle=%0b exp 40/1", free_count, all_idle);
    end
    checks++;
    if (gen_vacant !== {NUM_WF{1'b1}}) begin
      errors++; $display("FAIL reset_vacant got=%h exp all ones", gen_vacant);
    end
    checks++;
    if ({alloc_ack, gen_wr, gen_halt, done_ready, retire_valid, err_double_free} !== '0) begin
      errors++; $display("FAIL reset_strobes ack=%0b wr=%0b halt=%0b rdy=%b ret=%0b err=%0b exp 0",
                         alloc_ack, gen_wr, gen_halt, done_ready, retire_valid, err_double_free);
    end
    tick();
  endtask

  task automatic test_alloc_basic();
    int exp, got;
    logic [TAG_W-1:0] tag;
    exp = mdl_lowest();
    alloc_req = 1'b1; alloc_tag = 15'h1234;
    @(negedge clk);
    checks++;
    if (gen_wr !== 1'b1 || alloc_ack !== 1'b0 || gen_tag !== 15'h1234) begin
      errors++; $display("FAIL alloc_wr_cycle wr=%0b ack=%0b tag=%h exp 1/0/1234", gen_wr, alloc_ack, gen_tag);
    end
    tick();
    @(negedge clk);
    checks++;
    if (alloc_ack !== 1'b1 || int'(alloc_wfid) != exp || free_count !== 7'd39) begin
      errors++; $display("FAIL alloc_ack_cycle ack=%0b wfid=%0d free=%0d exp 1/%0d/39", alloc_ack, alloc_wfid, free_count, exp);
    end
    tick();
    alloc_req = 1'b0;
    mdl_busy[exp] = 1'b1; mdl_tag[exp] = 15'h1234;
    tag = TAG_W'($urandom);
    exp = mdl_lowest();
    do_alloc(tag, 4, got);
    mdl_busy[exp] = 1'b1; mdl_tag[exp] = tag;
    @(negedge clk);
    checks++;
    if (got != exp || got != 1 || free_count !== 7'd38) begin
      errors++; $display("FAIL alloc_second wfid=%0d free=%0d exp 1/38", got, free_count);
    end
    tick();
  endtask

  task automatic test_fill();
    int exp, got, bad;
    logic [TAG_W-1:0] tag;
    bit saw;
    while (mdl_free() > 0) begin
      tag = TAG_W'($urandom);
      exp = mdl_lowest();
      do_alloc(tag, 4, got);
      checks++;
      if (got != exp) begin
        errors++; $display("FAIL fill_id got=%0d exp=%0d", got, exp);
        if (got < 0) break;
      end
      mdl_busy[exp] = 1'b1; mdl_tag[exp] = tag;
    end
    @(negedge clk);
    checks++;
    if (free_count !== 7'd0 || all_idle !== 1'b0) begin
      errors++; $display("FAIL full_count free=%0d all_idle=%0b exp 0/0", free_count, all_idle);
    end
    tick();
    tag = TAG_W'($urandom);
    alloc_req = 1'b1; alloc_tag = tag;
    saw = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (gen_wr || alloc_ack) saw = 1'b1;
      tick();
    end
    checks++;
    if (saw) begin errors++; $display("FAIL full_no_ack got grant exp none"); end
    done_valid = 2'b01; done_wfid[0 +: ID_W] = 6'd7;
    @(negedge clk);
    checks++;
    if (done_ready !== 2'b01 || gen_halt !== 1'b1 || alloc_ack !== 1'b0) begin
      errors++; $display("FAIL full_release rdy=%b halt=%0b ack=%0b exp 01/1/0", done_ready, gen_halt, alloc_ack);
    end
    mdl_busy[7] = 1'b0; mdl_rr = 1;
    tick();
    done_valid = '0;
    checks++;
    if (retire_valid !== 1'b1 || retire_wfid !== 6'd7 || retire_tag !== mdl_tag[7]) begin
      errors++; $display("FAIL full_retire v=%0b id=%0d tag=%h exp 1/7/%h", retire_valid, retire_wfid, retire_tag, mdl_tag[7]);
    end
    @(negedge clk);
    bad = (gen_wr !== 1'b1) ? 1 : 0;
    tick();
    @(negedge clk);
    checks++;
    if (bad != 0 || alloc_ack !== 1'b1 || alloc_wfid !== 6'd7) begin
      errors++; $display("FAIL refill_ack wr_late=%0d ack=%0b wfid=%0d exp 0/1/7", bad, alloc_ack, alloc_wfid);
    end
    tick();
    alloc_req = 1'b0;
    mdl_busy[7] = 1'b1; mdl_tag[7] = tag;
  endtask

  // Drives releases of random held ids from random sources; all_out keeps every source busy until empty.
  task automatic run_releases(input int iters, input bit all_out);
    logic [NUM_SRC-1:0] pend, exp_rdy;
    int pid [NUM_SRC];
    int cand [$];
    int w, s, exp_id;
    bit taken;
    logic [TAG_W-1:0] exp_tag;
    pend = '0;
    for (int it = 0; it < iters; it++) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (!pend[k] && (all_out || $urandom_range(0, 1) == 1)) begin
          cand.delete();
          for (int i = 0; i < NUM_WF; i++) begin
            taken = 1'b0;
            for (int j = 0; j < NUM_SRC; j++) if (pend[j] && pid[j] == i) taken = 1'b1;
            if (mdl_busy[i] && !taken) cand.push_back(i);
          end
          if (cand.size() > 0) begin
            pid[k] = cand[$urandom_range(0, cand.size() - 1)];
            pend[k] = 1'b1;
          end
        end
      end
      if (all_out && pend == '0) break;
      done_valid = pend;
      for (int k = 0; k < NUM_SRC; k++) done_wfid[k*ID_W +: ID_W] = ID_W'(pid[k]);
      @(negedge clk);
      w = -1;
      for (int off = 0; off < NUM_SRC; off++) begin
        s = (mdl_rr + off) % NUM_SRC;
        if (w < 0 && pend[s]) w = s;
      end
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      checks++;
      if (done_ready !== exp_rdy || gen_halt !== (w >= 0)) begin
        errors++; $display("FAIL rr_grant rdy=%b halt=%0b exp %b/%0b", done_ready, gen_halt, exp_rdy, w >= 0);
      end
      if (all_out) begin
        checks++;
        if (gen_wr !== 1'b0 || alloc_ack !== 1'b0) begin
          errors++; $display("FAIL drain_block wr=%0b ack=%0b exp 0/0", gen_wr, alloc_ack);
        end
      end
      exp_id = 0; exp_tag = '0;
      if (w >= 0) begin
        exp_id = pid[w]; exp_tag = mdl_tag[exp_id];
        mdl_busy[exp_id] = 1'b0; mdl_rr = (w + 1) % NUM_SRC; pend[w] = 1'b0;
      end
      tick();
      done_valid = pend;
      if (w >= 0) begin
        checks++;
        if (retire_valid !== 1'b1 || int'(retire_wfid) != exp_id || retire_tag !== exp_tag) begin
          errors++; $display("FAIL rr_retire v=%0b id=%0d tag=%h exp 1/%0d/%h", retire_valid, retire_wfid, retire_tag, exp_id, exp_tag);
        end
      end
      checks++;
      if (int'(free_count) != mdl_free()) begin
        errors++; $display("FAIL rr_count free=%0d exp=%0d", free_count, mdl_free());
      end
    end
    done_valid = '0;
  endtask

  task automatic test_rr_pair();
    logic [NUM_SRC-1:0] pend, exp_rdy;
    int ids [NUM_SRC];
    int w, s, order_ok;
    ids[0] = 3; ids[1] = 5;
    pend = 2'b11;
    done_valid = pend;
    done_wfid = {6'd5, 6'd3};
    order_ok = 1;
    for (int cyc = 0; cyc < NUM_SRC + 1 && pend != '0; cyc++) begin
      @(negedge clk);
      w = -1;
      for (int off = 0; off < NUM_SRC; off++) begin
        s = (mdl_rr + off) % NUM_SRC;
        if (w < 0 && pend[s]) w = s;
      end
      exp_rdy = '0;
      exp_rdy[w] = 1'b1;
      checks++;
      if (done_ready !== exp_rdy) begin
        errors++; $display("FAIL pair_ready got=%b exp=%b", done_ready, exp_rdy);
      end
      mdl_busy[ids[w]] = 1'b0; mdl_rr = (w + 1) % NUM_SRC; pend[w] = 1'b0;
      tick();
      done_valid = pend;
      checks++;
      if (retire_valid !== 1'b1 || int'(retire_wfid) != ids[w] || retire_tag !== mdl_tag[ids[w]]) begin
        errors++; $display("FAIL pair_retire v=%0b id=%0d tag=%h exp 1/%0d/%h", retire_valid, retire_wfid, retire_tag, ids[w], mdl_tag[ids[w]]);
      end
    end
    checks++;
    if (pend != '0) begin errors++; $display("FAIL pair_timeout pending=%b exp 00", pend); end
    done_valid = '0;
  endtask

  task automatic test_same_cycle();
    int exp, fc;
    logic [TAG_W-1:0] tag;
    tag = TAG_W'($urandom);
    exp = mdl_lowest();
    fc  = mdl_free();
    alloc_req = 1'b1; alloc_tag = tag;
    done_valid = 2'b01; done_wfid[0 +: ID_W] = 6'd2;
    @(negedge clk);
    checks++;
    if (gen_wr !== 1'b1 || gen_halt !== 1'b1) begin
      errors++; $display("FAIL same_strobes wr=%0b halt=%0b exp 1/1", gen_wr, gen_halt);
    end
    mdl_busy[2] = 1'b0; mdl_busy[exp] = 1'b1; mdl_tag[exp] = tag; mdl_rr = 1;
    tick();
    done_valid = '0;
    checks++;
    if (int'(free_count) != fc || gen_vacant[2] !== 1'b1 || gen_vacant[exp] !== 1'b0) begin
      errors++; $display("FAIL same_mask free=%0d v2=%0b v%0d=%0b exp %0d/1/0", free_count, gen_vacant[2], exp, gen_vacant[exp], fc);
    end
    checks++;
    if (alloc_ack !== 1'b1 || int'(alloc_wfid) != exp || retire_wfid !== 6'd2) begin
      errors++; $display("FAIL same_ack ack=%0b wfid=%0d ret=%0d exp 1/%0d/2", alloc_ack, alloc_wfid, retire_wfid, exp);
    end
    tick();
    alloc_req = 1'b0;
  endtask

  task automatic test_double_free();
    int fc;
    done_valid = 2'b01; done_wfid[0 +: ID_W] = 6'd9;
    @(negedge clk);
    checks++;
    if (gen_halt !== 1'b1) begin errors++; $display("FAIL dbl_first halt=%0b exp 1", gen_halt); end
    mdl_busy[9] = 1'b0; mdl_rr = 1;
    tick();
    fc = mdl_free();
    @(negedge clk);
    checks++;
    if (done_ready !== 2'b01 || gen_halt !== 1'b0) begin
      errors++; $display("FAIL dbl_grant rdy=%b halt=%0b exp 01/0", done_ready, gen_halt);
    end
    mdl_rr = 1;
    tick();
    done_valid = '0;
    checks++;
    if (retire_valid !== 1'b0 || err_double_free !== 1'b1 || int'(free_count) != fc) begin
      errors++; $display("FAIL dbl_effect ret=%0b err=%0b free=%0d exp 0/1/%0d", retire_valid, err_double_free, free_count, fc);
    end
    done_valid = 2'b10; done_wfid[ID_W +: ID_W] = 6'd45;
    @(negedge clk);
    checks++;
    if (done_ready !== 2'b10 || gen_halt !== 1'b0) begin
      errors++; $display("FAIL oor_grant rdy=%b halt=%0b exp 10/0", done_ready, gen_halt);
    end
    mdl_rr = 0;
    tick();
    done_valid = '0;
    checks++;
    if (retire_valid !== 1'b0 || int'(free_count) != fc) begin
      errors++; $display("FAIL oor_effect ret=%0b free=%0d exp 0/%0d", retire_valid, free_count, fc);
    end
  endtask

  task automatic test_drain_reset();
    bit saw;
    drain = 1'b1; alloc_req = 1'b1; alloc_tag = TAG_W'($urandom);
    saw = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (gen_wr || alloc_ack) saw = 1'b1;
      tick();
    end
    checks++;
    if (saw) begin errors++; $display("FAIL drain_hold got grant exp none"); end
    run_releases(200, 1'b1);
    @(negedge clk);
    checks++;
    if (all_idle !== 1'b1 || free_count !== 7'd40 || mdl_free() != NUM_WF) begin
      errors++; $display("FAIL drain_idle all_idle=%0b free=%0d model=%0d exp 1/40/40", all_idle, free_count, mdl_free());
    end
    checks++;
    if (err_double_free !== 1'b1) begin errors++; $display("FAIL err_sticky got=%0b exp 1", err_double_free); end
    tick();
    drain = 1'b0;
    @(negedge clk);
    checks++;
    if (gen_wr !== 1'b1) begin errors++; $display("FAIL undrain_wr got=%0b exp 1", gen_wr); end
    tick();
    checks++;
    if (alloc_ack !== 1'b1) begin errors++; $display("FAIL undrain_ack got=%0b exp 1", alloc_ack); end
    rst = 1'b1;
    #1;
    checks++;
    if (alloc_ack !== 1'b0 || gen_vacant !== {NUM_WF{1'b1}} || free_count !== 7'd40 || err_double_free !== 1'b0) begin
      errors++; $display("FAIL rst_in_ack ack=%0b vacant=%h free=%0d err=%0b exp 0/all ones/40/0", alloc_ack, gen_vacant, free_count, err_double_free);
    end
    alloc_req = 1'b0;
    mdl_reset();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_alloc_basic();
    test_fill();
    test_rr_pair();
    test_same_cycle();
    test_double_free();
    run_releases(40, 1'b0);
    test_drain_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
